// File: rtl/region_pr_scheduler_if.sv
// Bundle of the metadata streams, region statistics and partial-reconfiguration
// handshake that connect region_pr_scheduler to its surroundings.
interface region_pr_scheduler_if #(
    parameter int HTTP_META_WIDTH   = 8,
    parameter int OPERATOR_ID_WIDTH = 2,
    parameter int N_REGIONS         = 4,
    parameter int PNTR_BITS         = 2
);
    localparam int SEL_W  = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
    localparam int STAT_W = N_REGIONS * (OPERATOR_ID_WIDTH + PNTR_BITS);

    // Metadata sink
    logic                         meta_in_tvalid;
    logic                         meta_in_tready;
    logic [HTTP_META_WIDTH-1:0]   meta_in_tdata;

    // Live per-region statistics: {oid, load} per region
    logic [STAT_W-1:0]            region_stats_in;

    // Metadata source with region select
    logic                         meta_out_tvalid;
    logic                         meta_out_tready;
    logic [HTTP_META_WIDTH-1:0]   meta_out_tdata;
    logic [SEL_W-1:0]             lb_ctrl;

    // Reconfiguration engine handshake and status
    logic                         pr_req_valid;
    logic                         pr_req_ready;
    logic [SEL_W-1:0]             pr_region;
    logic [OPERATOR_ID_WIDTH-1:0] pr_oid;
    logic                         pr_done;
    logic                         pr_err;
    logic [15:0]                  pr_count;

    // Scheduler side
    modport slave (
        input  meta_in_tvalid, meta_in_tdata, region_stats_in,
        input  meta_out_tready, pr_req_ready, pr_done,
        output meta_in_tready, meta_out_tvalid, meta_out_tdata, lb_ctrl,
        output pr_req_valid, pr_region, pr_oid, pr_err, pr_count
    );

    // Environment side (metadata producer/consumer, PR engine, region monitor)
    modport master (
        output meta_in_tvalid, meta_in_tdata, region_stats_in,
        output meta_out_tready, pr_req_ready, pr_done,
        input  meta_in_tready, meta_out_tvalid, meta_out_tdata, lb_ctrl,
        input  pr_req_valid, pr_region, pr_oid, pr_err, pr_count
    );
endinterface

// File: rtl/region_pr_scheduler.sv
// Dispatches one metadata beat at a time to a compute region. Regions already
// holding the beat's operator are preferred (least loaded, lowest index); when
// none holds it, an idle region is reconfigured first. All outputs registered.
module region_pr_scheduler #(
    parameter int HTTP_META_WIDTH   = 8,
    parameter int OPERATOR_ID_WIDTH = 2,
    parameter int N_REGIONS         = 4,
    parameter int QDEPTH            = 4,
    parameter int PNTR_BITS         = $clog2(QDEPTH),
    parameter int PR_TIMEOUT        = 1024
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    region_pr_scheduler_if.slave bus
);
    localparam int SEL_W  = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
    localparam int STAT_W = OPERATOR_ID_WIDTH + PNTR_BITS;
    localparam int TMO_W  = (PR_TIMEOUT > 1) ? $clog2(PR_TIMEOUT) : 1;

    localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(PR_TIMEOUT - 1);
    localparam logic [PNTR_BITS-1:0] LOAD_FULL = '1;

    typedef enum logic [2:0] {
        IDLE,
        DECIDE,
        PR_REQ,
        PR_WAIT,
        OUT
    } state_e;

    // Control state
    state_e                       state_q,           state_d;
    logic                         meta_in_tready_q,  meta_in_tready_d;
    logic                         meta_out_tvalid_q, meta_out_tvalid_d;
    logic                         pr_req_valid_q,    pr_req_valid_d;
    logic [SEL_W-1:0]             lb_ctrl_q,         lb_ctrl_d;
    logic [SEL_W-1:0]             pr_region_q,       pr_region_d;
    logic [OPERATOR_ID_WIDTH-1:0] pr_oid_q,          pr_oid_d;
    logic                         pr_err_q,          pr_err_d;
    logic [15:0]                  pr_count_q,        pr_count_d;

    // Beat payload and working registers (no reset needed)
    logic [HTTP_META_WIDTH-1:0]   beat_q,            beat_d;
    logic [HTTP_META_WIDTH-1:0]   meta_out_tdata_q,  meta_out_tdata_d;
    logic [OPERATOR_ID_WIDTH-1:0] req_oid_q,         req_oid_d;
    logic [SEL_W-1:0]             sel_q,             sel_d;
    logic [TMO_W-1:0]             tmo_cnt_q,         tmo_cnt_d;

    // Region decision
    logic [OPERATOR_ID_WIDTH-1:0] reg_oid  [N_REGIONS];
    logic [PNTR_BITS-1:0]         reg_load [N_REGIONS];
    logic                         hit_any;
    logic                         nf_hit_found;
    logic [SEL_W-1:0]             hit_sel;
    logic [PNTR_BITS-1:0]         hit_load;
    logic                         victim_found;
    logic [SEL_W-1:0]             victim_sel;

    // Split the flat statistics word into per-region operator and load fields
    always_comb begin
        for (int i = 0; i < N_REGIONS; i++) begin
            reg_oid[i]  = bus.region_stats_in[i*STAT_W + PNTR_BITS +: OPERATOR_ID_WIDTH];
            reg_load[i] = bus.region_stats_in[i*STAT_W +: PNTR_BITS];
        end
    end

    // Pick the least-loaded non-full hit and the lowest-index idle victim
    always_comb begin
        hit_any      = 1'b0;
        nf_hit_found = 1'b0;
        hit_sel      = '0;
        hit_load     = '0;
        victim_found = 1'b0;
        victim_sel   = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (reg_oid[i] == req_oid_q) begin
                hit_any = 1'b1;
                // Strict less-than keeps the lowest index on equal load
                if ((reg_load[i] != LOAD_FULL) &&
                    (!nf_hit_found || (reg_load[i] < hit_load))) begin
                    nf_hit_found = 1'b1;
                    hit_sel      = SEL_W'(i);
                    hit_load     = reg_load[i];
                end
            end
            if (!victim_found && (reg_load[i] == '0)) begin
                victim_found = 1'b1;
                victim_sel   = SEL_W'(i);
            end
        end
    end

    // Next-state and next-output computation for the dispatch sequence
    always_comb begin
        state_d           = state_q;
        meta_out_tvalid_d = meta_out_tvalid_q;
        pr_req_valid_d    = pr_req_valid_q;
        lb_ctrl_d         = lb_ctrl_q;
        pr_region_d       = pr_region_q;
        pr_oid_d          = pr_oid_q;
        pr_err_d          = pr_err_q;
        pr_count_d        = pr_count_q;
        beat_d            = beat_q;
        meta_out_tdata_d  = meta_out_tdata_q;
        req_oid_d         = req_oid_q;
        sel_d             = sel_q;
        tmo_cnt_d         = tmo_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.meta_in_tvalid && meta_in_tready_q) begin
                    beat_d    = bus.meta_in_tdata;
                    req_oid_d = bus.meta_in_tdata[OPERATOR_ID_WIDTH-1:0];
                    state_d   = DECIDE;
                end
            end
            DECIDE: begin
                if (nf_hit_found) begin
                    sel_d             = hit_sel;
                    lb_ctrl_d         = hit_sel;
                    meta_out_tdata_d  = beat_q;
                    meta_out_tvalid_d = 1'b1;
                    state_d           = OUT;
                end else if (!hit_any && victim_found) begin
                    // Only reconfigure when no region holds the operator at all;
                    // a busy-but-loaded region is waited on instead.
                    sel_d          = victim_sel;
                    pr_region_d    = victim_sel;
                    pr_oid_d       = req_oid_q;
                    pr_req_valid_d = 1'b1;
                    state_d        = PR_REQ;
                end
            end
            PR_REQ: begin
                if (bus.pr_req_ready) begin
                    pr_req_valid_d = 1'b0;
                    tmo_cnt_d      = '0;
                    state_d        = PR_WAIT;
                end
            end
            PR_WAIT: begin
                // Completion takes priority over a coincident timeout
                if (bus.pr_done) begin
                    if (pr_count_q != 16'hFFFF) begin
                        pr_count_d = pr_count_q + 16'd1;
                    end
                    lb_ctrl_d         = sel_q;
                    meta_out_tdata_d  = beat_q;
                    meta_out_tvalid_d = 1'b1;
                    state_d           = OUT;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    pr_err_d = 1'b1;
                    state_d  = DECIDE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            OUT: begin
                if (bus.meta_out_tready) begin
                    meta_out_tvalid_d = 1'b0;
                    state_d           = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready is a registered decode of the next state so it drops the
        // cycle a beat is taken and stays low through reset.
        meta_in_tready_d = (state_d == IDLE);
    end

    // State register: control reset synchronously, payload registers free-running
    always_ff @(posedge aclk) begin
        beat_q           <= beat_d;
        meta_out_tdata_q <= meta_out_tdata_d;
        req_oid_q        <= req_oid_d;
        sel_q            <= sel_d;
        tmo_cnt_q        <= tmo_cnt_d;
        if (!aresetn) begin
            state_q           <= IDLE;
            meta_in_tready_q  <= 1'b0;
            meta_out_tvalid_q <= 1'b0;
            pr_req_valid_q    <= 1'b0;
            lb_ctrl_q         <= '0;
            pr_region_q       <= '0;
            pr_oid_q          <= '0;
            pr_err_q          <= 1'b0;
            pr_count_q        <= '0;
        end else begin
            state_q           <= state_d;
            meta_in_tready_q  <= meta_in_tready_d;
            meta_out_tvalid_q <= meta_out_tvalid_d;
            pr_req_valid_q    <= pr_req_valid_d;
            lb_ctrl_q         <= lb_ctrl_d;
            pr_region_q       <= pr_region_d;
            pr_oid_q          <= pr_oid_d;
            pr_err_q          <= pr_err_d;
            pr_count_q        <= pr_count_d;
        end
    end

    assign bus.meta_in_tready  = meta_in_tready_q;
    assign bus.meta_out_tvalid = meta_out_tvalid_q;
    assign bus.meta_out_tdata  = meta_out_tdata_q;
    assign bus.lb_ctrl         = lb_ctrl_q;
    assign bus.pr_req_valid    = pr_req_valid_q;
    assign bus.pr_region       = pr_region_q;
    assign bus.pr_oid          = pr_oid_q;
    assign bus.pr_err          = pr_err_q;
    assign bus.pr_count        = pr_count_q;

endmodule
